// File: rtl/wfifo_wr_arbiter.sv
// wfifo_wr_arbiter: round-robin, packet-locked sharing of the async FIFO write port,
// admitting new packets only when enough free entries remain.
module wfifo_wr_arbiter #(
    parameter int DSIZE       = 8,
    parameter int ADDRSIZE    = 4,
    parameter int NREQ        = 3,
    parameter int PKT_RESERVE = 4,
    parameter int AFULL_LVL   = 12
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    input  logic [NREQ*DSIZE-1:0]   din,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         gnt,
    output logic                    fifo_winc,
    output logic [DSIZE-1:0]        fifo_wdata,
    input  logic                    fifo_wfull,
    input  logic [ADDRSIZE:0]       wq2_rptr,
    output logic [ADDRSIZE:0]       wfill,
    output logic                    walmost_full,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PKT  = 1'b1;

    logic [0:0]      state;
    logic [IW-1:0]   rr_last, own, cand, idx;
    logic            cand_ok, own_last;
    logic [ADDRSIZE:0] wcnt, wcnt_next, rbin, fill_next;

    for (genvar j = 0; j <= ADDRSIZE; j++) begin : g_g2b
        assign rbin[j] = ^wq2_rptr[ADDRSIZE:j];
    end

    assign busy      = state == PKT;
    assign ack       = busy ? gnt & req & {NREQ{~fifo_wfull}} : '0;
    assign fifo_winc = |ack;
    assign own_last  = |(gnt & last);
    assign wcnt_next = wcnt + {{ADDRSIZE{1'b0}}, fifo_winc};
    // Modulo subtraction absorbs pointer wrap; a stale read pointer only overstates fill.
    assign fill_next = wcnt_next - rbin;

    always_comb begin
        cand_ok    = 1'b0;
        cand       = '0;
        idx        = '0;
        fifo_wdata = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(rr_last) + k) % NREQ);
            if (req[idx]) begin
                cand_ok = 1'b1;
                cand    = idx;
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (own == IW'(i)) fifo_wdata = din[i*DSIZE +: DSIZE];
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state        <= IDLE;
            gnt          <= '0;
            own          <= '0;
            rr_last      <= IW'(NREQ - 1);
            wcnt         <= '0;
            wfill        <= '0;
            walmost_full <= 1'b0;
        end else begin
            wcnt         <= wcnt_next;
            wfill        <= fill_next;
            walmost_full <= fill_next >= (ADDRSIZE+1)'(AFULL_LVL);
            if (state == IDLE) begin
                if (cand_ok && wfill <= (ADDRSIZE+1)'((1 << ADDRSIZE) - PKT_RESERVE)) begin
                    state <= PKT;
                    gnt   <= NREQ'(1) << cand;
                    own   <= cand;
                end
            end else if (fifo_winc && own_last) begin
                state   <= IDLE;
                gnt     <= '0;
                rr_last <= own;
            end
        end
    end
endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// tb_wfifo_wr_arbiter: directed scenarios checked every cycle against a
// behavioural arbitration/occupancy model, plus hand-computed expectations.
`timescale 1ns/1ps
module tb_wfifo_wr_arbiter;
    localparam int N = 3, D = 8, A = 4, DEPTH = 16, IW = 2;

    logic wclk = 1'b0, wrst_n = 1'b0, fifo_wfull = 1'b0;
    logic [N-1:0] req, last, ack, gnt, acc, gnt_prev;
    logic [N*D-1:0] din;
    logic fifo_winc, walmost_full, busy;
    logic [D-1:0] fifo_wdata;
    logic [A:0] wq2_rptr, wfill;

    int checks = 0, failures = 0;
    int pkts[N], plen[N], left[N], seq[N];
    int bcnt = 0, base = 0, rd_mode = 0, rbin_set = 0;
    int wlog[$], glog[$];
    int m_own = -1, m_rr = N - 1, m_wcnt = 0, m_fill = 0;
    int n_own, n_rr, n_wcnt, n_fill, cand;

    always #5 wclk = ~wclk;

    wfifo_wr_arbiter dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .din(din),
        .ack(ack), .gnt(gnt), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
        .fifo_wfull(fifo_wfull), .wq2_rptr(wq2_rptr), .wfill(wfill),
        .walmost_full(walmost_full), .busy(busy)
    );

    always_comb
        for (int i = 0; i < N; i++) begin
            req[i]         = pkts[i] > 0;
            last[i]        = left[i] == 1;
            din[i*D +: D]  = {i[1:0], seq[i][5:0]};
        end

    function automatic logic [A:0] gray(int b);
        logic [A:0] x;
        x = b[A:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int g2b(logic [A:0] g);
        int b = 0;
        for (int i = 0; i <= A; i++) b = b ^ int'(g >> i);
        return b;
    endfunction

    function automatic bit bit_of(logic [N-1:0] v, int i);
        return v[i[IW-1:0]];
    endfunction

    // Model: owner index (-1 when idle), last winner, write count and fill as plain integers.
    always_comb begin
        n_own  = m_own;
        n_rr   = m_rr;
        n_wcnt = m_wcnt;
        cand   = -1;
        if (m_own < 0) begin
            for (int k = 1; k <= N; k++)
                if (cand < 0 && bit_of(req, (m_rr + k) % N)) cand = (m_rr + k) % N;
            if (cand >= 0 && DEPTH - m_fill >= 4) n_own = cand;
        end else if (bit_of(req, m_own) && !fifo_wfull) begin
            n_wcnt = (m_wcnt + 1) % 32;
            if (bit_of(last, m_own)) begin
                n_rr  = m_own;
                n_own = -1;
            end
        end
        n_fill = (n_wcnt - g2b(wq2_rptr) + 32) % 32;
    end

    always @(posedge wclk or negedge wrst_n)
        if (!wrst_n) begin
            m_own  <= -1;
            m_rr   <= N - 1;
            m_wcnt <= 0;
            m_fill <= 0;
        end else begin
            m_own  <= n_own;
            m_rr   <= n_rr;
            m_wcnt <= n_wcnt;
            m_fill <= n_fill;
        end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        int ea;
        ea = (m_own >= 0 && bit_of(req, m_own) && !fifo_wfull) ? (1 << m_own) : 0;
        chk("gnt", int'(gnt), m_own < 0 ? 0 : 1 << m_own);
        chk("busy", int'(busy), int'(m_own >= 0));
        chk("ack", int'(ack), ea);
        chk("winc", int'(fifo_winc), int'(ea != 0));
        if (ea != 0) chk("wdata", int'(fifo_wdata), int'(8'(din >> (m_own * D))));
        chk("wfill", int'(wfill), m_fill);
        chk("afull", int'(walmost_full), int'(m_fill >= 12));
    endtask

    // One cycle: compare at negedge, log, move the reader, then advance requesters after the edge.
    task automatic step();
        int rb;
        @(negedge wclk);
        compare();
        acc = ack;
        if (fifo_winc) begin
            wlog.push_back(int'(fifo_wdata));
            bcnt++;
        end
        if (gnt != 0 && gnt_prev == 0) glog.push_back($clog2(gnt));
        gnt_prev = gnt;
        rb = rd_mode == 1 ? bcnt - base :
             rd_mode == 2 ? ((bcnt - base) < 3 ? 0 : bcnt - base - 3) : rbin_set;
        wq2_rptr = gray(rb);
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) begin
                seq[i]++;
                if (left[i] == 1) begin
                    left[i] = plen[i];
                    pkts[i]--;
                end else left[i]--;
            end
        #1;
    endtask

    task automatic start(int i, int n, int len);
        plen[i] = len;
        left[i] = len;
        pkts[i] = n;
    endtask

    task automatic wait_done(string nm, int lim);
        int t = 0;
        while ((pkts[0] + pkts[1] + pkts[2] != 0 || busy) && t < lim) begin
            step();
            t++;
        end
        chk({nm, "_timeout"}, int'(t < lim), 1);
    endtask

    initial begin
        int w0, g0, t, mx, af_seen, b0;
        int exp_g[4] = '{0, 1, 2, 0};
        int exp_w[8] = '{'h00, 'h01, 'h40, 'h41, 'h80, 'h81, 'h02, 'h03};
        acc = '0;
        gnt_prev = '0;
        wq2_rptr = '0;
        repeat (2) @(posedge wclk);
        #1;
        step();
        wrst_n = 1'b1;

        // 1: idle after reset
        repeat (10) begin
            step();
            chk("t1_gnt", int'(gnt), 0);
            chk("t1_winc", int'(fifo_winc), 0);
            chk("t1_wfill", int'(wfill), 0);
        end

        // 2: round robin with a fast reader
        rd_mode = 1;
        w0 = wlog.size();
        g0 = glog.size();
        start(0, 2, 2);
        start(1, 1, 2);
        start(2, 1, 2);
        wait_done("t2", 100);
        for (int k = 0; k < 4; k++)
            chk("t2_order", g0 + k < glog.size() ? glog[g0 + k] : -1, exp_g[k]);
        for (int k = 0; k < 8; k++)
            chk("t2_data", w0 + k < wlog.size() ? wlog[w0 + k] : -1, exp_w[k]);

        // 3: reservation gate with the reader stopped
        rbin_set = bcnt;
        rd_mode = 0;
        start(0, 1, 13);
        wait_done("t3a", 100);
        chk("t3_fill13", int'(wfill), 13);
        chk("t3_afull", int'(walmost_full), 1);
        start(1, 1, 2);
        repeat (4) begin
            step();
            chk("t3_block", int'(gnt), 0);
        end
        rbin_set = rbin_set + 2;
        t = 0;
        while (gnt == 0 && t < 6) begin
            step();
            t++;
        end
        chk("t3_grant", int'(gnt), 2);
        chk("t3_latency", t, 2);
        chk("t3_fill11", int'(wfill), 11);
        wait_done("t3b", 50);
        rd_mode = 1;

        // 4: full stall in the middle of requester 2's packet
        w0 = wlog.size();
        seq[2] = 0;
        start(2, 1, 6);
        t = 0;
        while (seq[2] < 2 && t < 20) begin
            step();
            t++;
        end
        chk("t4_reach", seq[2], 2);
        fifo_wfull = 1'b1;
        repeat (5) begin
            step();
            chk("t4_ack", int'(ack), 0);
            chk("t4_winc", int'(fifo_winc), 0);
            chk("t4_gnt", int'(gnt), 4);
        end
        fifo_wfull = 1'b0;
        wait_done("t4", 50);
        chk("t4_count", wlog.size() - w0, 6);
        for (int k = 0; k < 6; k++)
            chk("t4_data", w0 + k < wlog.size() ? wlog[w0 + k] : -1, 'h80 + k);

        // 5: lagging reader across pointer wrap
        rd_mode = 2;
        b0 = bcnt;
        mx = 0;
        af_seen = 0;
        start(0, 40, 1);
        t = 0;
        while ((pkts[0] != 0 || busy) && t < 300) begin
            step();
            t++;
            if (int'(wfill) > mx) mx = int'(wfill);
            if (walmost_full) af_seen = 1;
        end
        chk("t5_timeout", int'(t < 300), 1);
        chk("t5_fill_max", mx, 3);
        chk("t5_fill_end", int'(wfill), 3);
        chk("t5_afull", af_seen, 0);
        chk("t5_count", bcnt - b0, 40);

        // 6: asynchronous reset mid-packet
        rd_mode = 0;
        rbin_set = bcnt - 11;
        step();
        seq[1] = 0;
        start(1, 1, 4);
        t = 0;
        while (seq[1] < 1 && t < 10) begin
            step();
            t++;
        end
        chk("t6_pre_busy", int'(busy), 1);
        chk("t6_pre_afull", int'(walmost_full), 1);
        wrst_n = 1'b0;
        #1;
        chk("t6_gnt", int'(gnt), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_wfill", int'(wfill), 0);
        chk("t6_afull", int'(walmost_full), 0);
        for (int i = 0; i < N; i++) pkts[i] = 0;
        rbin_set = 0;
        base = bcnt;
        repeat (2) step();
        wrst_n = 1'b1;
        rd_mode = 1;
        g0 = glog.size();
        start(0, 1, 2);
        start(1, 1, 2);
        start(2, 1, 2);
        wait_done("t6", 60);
        chk("t6_first", g0 < glog.size() ? glog[g0] : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wfifo_wr_arbiter.md
Name: wfifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO; sits in the wclk domain in front of the FIFO write port.
- Shares the single write port among NREQ packet requesters using round-robin arbitration with packet locking.
- Tracks FIFO occupancy from its own write count and the synchronized Gray read pointer.
- Admits a new packet only if at least PKT_RESERVE free entries exist.

Parameters:
- DSIZE, 8, data width per beat.
- ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE.
- NREQ, 3, number of requesters (2..8).
- PKT_RESERVE, 4, free entries required before granting a new packet (1..2^ADDRSIZE).
- AFULL_LVL, 12, fill level at or above which walmost_full asserts.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester beat-valid.
- last  input  NREQ  per-requester end-of-packet flag, qualified by req.
- din  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- ack  output  NREQ  beat accepted this cycle (combinational).
- gnt  output  NREQ  registered one-hot owner of the write port.
- fifo_winc  output  1  FIFO write increment (combinational).
- fifo_wdata  output  DSIZE  data to the FIFO, muxed from din of the owner.
- fifo_wfull  input  1  registered full flag from the FIFO write-pointer logic.
- wq2_rptr  input  ADDRSIZE+1  read pointer, Gray code, already synchronized into wclk.
- wfill  output  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
- walmost_full  output  1  registered, asserted when wfill >= AFULL_LVL.
- busy  output  1  asserted while state == PKT.

Behaviour:

Reset (wrst_n low, asynchronous):
- state = IDLE, gnt = 0, rr_last = NREQ-1 (so requester 0 has first priority).
- wcnt = 0, wfill = 0, walmost_full = 0, busy = 0.
- A reset mid-packet abandons the packet; no partial-packet recovery.

Occupancy:
- wcnt is a binary counter, ADDRSIZE+1 bits, incremented on every fifo_winc.
- rbin = Gray-to-binary(wq2_rptr).
- wfill <= (wcnt_next - rbin) modulo 2^(ADDRSIZE+1), registered.
- free = 2^ADDRSIZE - wfill.
- Pointer wrap is handled by the modulo arithmetic. A stale read pointer only overstates fill, which is safe.

State IDLE:
- ack = 0, fifo_winc = 0.
- Candidate = first requester with req set, scanning from rr_last+1 upward with wrap.
- If a candidate exists and free >= PKT_RESERVE: gnt <= onehot(candidate), state <= PKT.
- Otherwise remain in IDLE.
- Arbitration costs exactly one cycle; the first beat can be accepted the cycle after the decision.

State PKT (owner g):
- ack[g] = req[g] & ~fifo_wfull; all other ack bits = 0.
- fifo_winc = ack[g], fifo_wdata = din[g].
- If req[g] is low, the cycle is a bubble: the grant is held and no timeout applies.
- If fifo_wfull is high, the owner stalls; data must be held by the requester.
- On ack[g] & last[g]: state <= IDLE, gnt <= 0, rr_last <= g.
- Back-to-back packets from different requesters therefore have exactly one idle cycle between them.

Boundary conditions:
- PKT_RESERVE is advisory. A packet longer than the free space stalls on fifo_wfull and never overflows.
- fifo_winc is never asserted while fifo_wfull = 1.
- Non-owner requests are ignored until the current packet ends.
- last without req has no effect.
- Single-beat packets (req & last on the first beat) are legal.
- wfill = 2^ADDRSIZE (full) is representable.

Test Plan:
1. Reset then idle: with req = 0 for 10 cycles -> gnt = 0, fifo_winc never high, wfill = 0, wq2_rptr = 0.
2. Round-robin: req = 3'b111 continuously, every requester sends a 2-beat packet, reader fast -> grant order 0, 1, 2, 0; one idle cycle between packets; fifo_wdata sequence matches din of the owner.
3. Reservation gate: reader stopped, PKT_RESERVE = 4; requester 0 writes 13 beats (wfill = 13, free = 3); requester 1 then requests -> no grant. Then drive wq2_rptr to Gray(2) -> wfill = 11, free = 5 -> gnt = 3'b010 within 2 cycles.
4. Full stall mid-packet: fifo_wfull forced high for 5 cycles during requester 2's packet -> ack = 0 and fifo_winc = 0 throughout, gnt held at 3'b100; the packet resumes with no beat lost or duplicated.
5. Pointer wrap: stream 40 single-beat packets with a reader lagging by 3 entries -> wfill stays at 3 across wcnt wrap at 32; walmost_full stays 0.
6. Reset mid-packet: assert wrst_n low during beat 2 of a 4-beat packet -> gnt, busy, wfill, and walmost_full clear immediately. After release, requester 0 wins first.
